// File: rtl/pipe_dbg_pkg.sv
// Shared definitions for the pipeline debug blocks.
//   dump_state_e : register-dump transmitter FSM states
//   REG_ADDR_W   : architectural register index width
//   REG_DATA_W   : architectural register data width
//   dump_beat_t  : one dumped register beat {index, data, last, stamp}
package pipe_dbg_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        READ,
        SEND,
        DONE
    } dump_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] index;
        logic [REG_DATA_W-1:0] data;
        logic                  last;
        logic [31:0]           stamp;
    } dump_beat_t;

endpackage

// File: rtl/regfile_dump_tx_cycle_counter.sv
// Free-running 32-bit cycle counter.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, clears the count
//   count_o : current count, increments every cycle, wraps to 0
module cycle_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_dump_tx.sv
// Register-file dump transmitter: stalls the pipeline, lets in-flight
// instructions drain, then streams {index, value} beats over valid/ready.
//   clk, rst            : clock and synchronous active-high reset
//   start               : dump request, honoured only when idle
//   first_reg, last_reg : inclusive index range, wraps modulo NUM_REGS
//   stall_req           : freezes the pipeline for the whole dump
//   rf_raddr, rf_rdata  : dedicated combinational register-file read port
//   tx_valid, tx_ready  : beat handshake
//   tx_index, tx_data   : beat payload
//   tx_last             : final beat of the dump
//   tx_stamp            : cycle count captured when the dump was accepted
//   busy                : any state other than idle
//   done                : one-cycle pulse after the final beat is accepted
import pipe_dbg_pkg::*;

module regfile_dump_tx #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned ADDR_W       = REG_ADDR_W,
    parameter int unsigned DATA_W       = REG_DATA_W,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic              stall_req,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] tx_index,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic [31:0]       tx_stamp,
    output logic              busy,
    output logic              done
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    // One bit wider than the index so a full-file dump count fits.
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [3:0]        drain_q, drain_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [31:0]       stamp_q, stamp_d;
    logic [31:0]       cycle_cnt;

    cycle_counter u_cycle_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .count_o (cycle_cnt)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        drain_d   = drain_q;
        idx_d     = idx_q;
        data_d    = data_q;
        last_d    = last_q;
        stamp_d   = stamp_q;
        stall_req = 1'b0;
        tx_valid  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rf_raddr  = '0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    stamp_d = cycle_cnt;
                    cur_d   = first_reg;
                    // Index subtraction wraps naturally at ADDR_W bits.
                    rem_d   = {1'b0, ADDR_W'(last_reg - first_reg)} + (ADDR_W+1)'(1);
                    drain_d = 4'(DRAIN_CYCLES);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall_req = 1'b1;
                drain_d   = drain_q - 4'd1;
                if (drain_q == 4'd1) begin
                    state_d = READ;
                end
            end
            READ: begin
                stall_req = 1'b1;
                rf_raddr  = cur_q;
                idx_d     = cur_q;
                data_d    = rf_rdata;
                last_d    = (rem_q == (ADDR_W+1)'(1));
                state_d   = SEND;
            end
            SEND: begin
                stall_req = 1'b1;
                tx_valid  = 1'b1;
                if (tx_ready) begin
                    cur_d   = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + ADDR_W'(1);
                    rem_d   = rem_q - (ADDR_W+1)'(1);
                    state_d = last_q ? DONE : READ;
                end
            end
            DONE: begin
                done    = 1'b1;
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            drain_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            stamp_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            stamp_q <= stamp_d;
        end
    end

    assign tx_index = idx_q;
    assign tx_data  = data_q;
    assign tx_last  = last_q;
    assign tx_stamp = stamp_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
module tb_regfile_dump_tx;
    import pipe_dbg_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned DC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_reg, last_reg;
    logic          stall_req;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [AW-1:0] tx_index;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic [31:0]   tx_stamp;
    logic          busy, done;

    always #5 clk = ~clk;

    regfile_dump_tx #(
        .NUM_REGS     (NR),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .stall_req (stall_req),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_index  (tx_index),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_stamp  (tx_stamp),
        .busy      (busy),
        .done      (done)
    );

    // Register file model with a combinational debug read port.
    logic [DW-1:0] regs [NR];
    always_comb rf_rdata = regs[rf_raddr];

    // Reference cycle count: cycles elapsed since reset was last applied.
    int unsigned mcnt = 0;
    always @(posedge clk) mcnt <= rst ? 0 : mcnt + 1;

    dump_beat_t sb[$];
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int got_dones = 0;
    int exp_dones = 0;
    logic rand_en = 1'b0;
    logic ready_force = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sole driver of tx_ready, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        tx_ready = rand_en ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Monitor: pops expected beats on each handshake, checks hold stability.
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [AW-1:0] pi = '0;
    logic [DW-1:0] pd = '0;
    always @(negedge clk) begin
        dump_beat_t e;
        if (rst) begin
            sb.delete();
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 64'(tx_valid), 64'd1);
                chk("hold_index", 64'(tx_index), 64'(pi));
                chk("hold_data", 64'(tx_data), 64'(pd));
                chk("hold_last", 64'(tx_last), 64'(pl));
            end
            if (tx_valid) chk("stall_during_send", 64'(stall_req), 64'd1);
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: index %0d data 0x%0h, expected no beat", tx_index, tx_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_index", 64'(tx_index), 64'(e.index));
                    chk("beat_data", 64'(tx_data), 64'(e.data));
                    chk("beat_last", 64'(tx_last), 64'(e.last));
                    chk("beat_stamp", 64'(tx_stamp), 64'(e.stamp));
                end
                beats_seen++;
            end
            if (done) begin
                got_dones++;
                chk("done_after_all_beats", 64'(sb.size()), 64'd0);
            end
            pv = tx_valid;
            pr = tx_ready;
            pi = tx_index;
            pd = tx_data;
            pl = tx_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int t = 0;
        tick();
        while ((busy || sb.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, expected idle", busy, sb.size());
        end
    endtask

    task automatic wait_beats(input int target);
        int t = 0;
        while (beats_seen < target && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: seen=%0d, expected %0d", beats_seen, target);
        end
    endtask

    // Issues a dump; optionally an in-flight writeback lands in the first
    // stalled cycle. Returns at the negedge where the first beat is valid.
    task automatic do_dump(input int f, input int l, input bit wb_en, input int wb_idx,
                           input logic [DW-1:0] wb_val);
        int n;
        int idx;
        dump_beat_t b;
        logic [31:0] st;
        wait_idle();
        chk("stall_low_before_start", 64'(stall_req), 64'd0);
        st = mcnt;
        n = ((l - f + NR) % NR) + 1;
        for (int i = 0; i < n; i++) begin
            idx = (f + i) % NR;
            b.index = AW'(idx);
            b.data  = (wb_en && idx == wb_idx) ? wb_val : regs[idx];
            b.last  = (i == n - 1);
            b.stamp = st;
            sb.push_back(b);
        end
        first_reg = AW'(f);
        last_reg  = AW'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (wb_en) regs[wb_idx] = wb_val;
        for (int k = 0; k <= int'(DC) + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("stall_after_start", 64'(stall_req), 64'd1);
                chk("busy_after_start", 64'(busy), 64'd1);
            end
            if (k == int'(DC)) begin
                chk("read_addr_at_drain_end", 64'(rf_raddr), 64'(f));
                chk("no_valid_before_read", 64'(tx_valid), 64'd0);
            end
            if (k == int'(DC) + 1) chk("first_beat_latency", 64'(tx_valid), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        rst = 1'b1;
        start = 1'b0;
        first_reg = '0;
        last_reg = '0;
        for (int i = 0; i < int'(NR); i++) regs[i] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_last", 64'(tx_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_index", 64'(tx_index), 64'd0);
        chk("rst_data", 64'(tx_data), 64'd0);
        chk("rst_stamp", 64'(tx_stamp), 64'd0);
        chk("rst_raddr", 64'(rf_raddr), 64'd0);
        tick();
        rst = 1'b0;

        // Full dump after 12 warm-up cycles.
        repeat (11) tick();
        do_dump(0, 31, 1'b0, 0, '0);
        chk("stamp_after_warmup", 64'(tx_stamp), 64'd12);
        exp_dones++;
        wait_idle();
        chk("done_once_full_dump", 64'(got_dones), 64'd1);

        // Targeted range with known contents.
        regs[19] = 32'd0;
        regs[20] = 32'd10;
        regs[21] = 32'd15;
        do_dump(19, 21, 1'b0, 0, '0);
        exp_dones++;

        // Wrap-around range.
        do_dump(30, 1, 1'b0, 0, '0);
        exp_dones++;

        // Backpressure on beat 2 for 5 cycles.
        base = beats_seen;
        do_dump(5, 12, 1'b0, 0, '0);
        wait_beats(base + 1);
        ready_force = 1'b0;
        repeat (5) tick();
        ready_force = 1'b1;
        exp_dones++;

        // Randomized ranges, random ready, in-flight writeback during drain.
        rand_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            do_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b1,
                    int'($urandom_range(0, 31)), $urandom);
            exp_dones++;
        end
        wait_idle();
        rand_en = 1'b0;

        // A start while busy must be ignored.
        do_dump(0, 7, 1'b0, 0, '0);
        tick();
        first_reg = AW'(20);
        last_reg = AW'(25);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_dones++;
        wait_idle();
        chk("done_count_after_busy_start", 64'(got_dones), 64'(exp_dones));

        // Reset during beat 3 abandons the dump.
        base = beats_seen;
        do_dump(10, 20, 1'b0, 0, '0);
        wait_beats(base + 2);
        t = 0;
        while (!tx_valid && t < 20) begin
            tick();
            t++;
        end
        chk("beat3_presented", 64'(tx_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_stall", 64'(stall_req), 64'd0);
        chk("post_rst_valid", 64'(tx_valid), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_stamp", 64'(tx_stamp), 64'd0);
        repeat (2) tick();
        do_dump(3, 6, 1'b0, 0, '0);
        chk("stamp_after_reset", 64'(tx_stamp), 64'd3);
        exp_dones++;
        wait_idle();

        chk("done_pulses_total", 64'(got_dones), 64'(exp_dones));
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump_tx.md
Name: regfile_dump_tx

Overview:
- Hardware debug transmitter that freezes the pipelined processor and streams architectural register contents out as {index, value} beats over a valid/ready interface.
- Sits beside the register file in the pipeline top and uses a dedicated combinational read port on the register file.
- Stamps each dump with a free-running cycle count so a downstream capture block or bench can check register values at a known cycle without probing internal hierarchy.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register index width; NUM_REGS must equal 2**ADDR_W.
- DATA_W, 32, register data width.
- DRAIN_CYCLES, 4, cycles to wait after stall assertion so in-flight instructions reach writeback; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle dump request; sampled only in IDLE.
- first_reg  in  ADDR_W  first register index to send; captured on accepted start.
- last_reg  in  ADDR_W  last register index to send; captured on accepted start.
- stall_req  out  1  freezes PC and all pipeline registers while high.
- rf_raddr  out  ADDR_W  debug read address to the register file.
- rf_rdata  in  DATA_W  combinational read data for rf_raddr.
- tx_valid  out  1  beat valid.
- tx_ready  in  1  downstream accepts the beat when tx_valid && tx_ready.
- tx_index  out  ADDR_W  register index of the current beat.
- tx_data  out  DATA_W  register value of the current beat.
- tx_last  out  1  high on the final beat of a dump.
- tx_stamp  out  32  cycle count captured at start; constant for the whole dump.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: state=IDLE; stall_req, tx_valid, tx_last, busy and done = 0; tx_index, tx_data, tx_stamp, rf_raddr and the cycle counter = 0.
- Reset takes priority mid-dump: the FSM returns to IDLE next cycle, stall_req drops, and the partial dump is abandoned with no done pulse.
- Cycle counter: 32-bit; increments every cycle after reset; wraps from 2^32-1 to 0.
- IDLE:
  - start=1 captures first_reg, last_reg and the current counter value into tx_stamp.
  - Sets cur=first_reg and remaining=((last_reg-first_reg) mod NUM_REGS)+1, using wrap-around: first=30, last=1 sends 30,31,0,1.
  - Moves to DRAIN; stall_req=1 from the next cycle.
- DRAIN:
  - stall_req=1; a down-counter is loaded with DRAIN_CYCLES.
  - After exactly DRAIN_CYCLES cycles in DRAIN, moves to READ.
- READ (1 cycle):
  - rf_raddr=cur; the block registers tx_data<=rf_rdata and tx_index<=cur.
  - tx_last<=(remaining==1); moves to SEND.
- SEND:
  - tx_valid=1; tx_index, tx_data and tx_last hold stable until handshake.
  - On tx_ready=1: cur<=cur+1 mod NUM_REGS and remaining<=remaining-1.
  - If tx_last was set, moves to DONE; otherwise to READ.
  - Throughput is 1 beat per 2 cycles with tx_ready held high.
- DONE (1 cycle): done=1, stall_req=0, tx_valid=0; returns to IDLE.
- start while busy is ignored and not queued.
- first==last gives a single beat with tx_last=1.
- The index width of remaining is ADDR_W+1 so a full 32-register dump is representable.
- stall_req stays asserted continuously from DRAIN through the SEND of the last beat. The register file receives no writes while stalled, so the dump is coherent.
- tx_ready is ignored when tx_valid=0.

Decomposition:
- Shared package pipe_dbg_pkg holds:
  - FSM state enum {IDLE, DRAIN, READ, SEND, DONE};
  - REG_ADDR_W=5 and REG_DATA_W=32;
  - the beat struct {index, data, last, stamp}.
- One natural sub-module, cycle_counter: a 32-bit free-running counter with synchronous reset, reusable by benches and the pipeline top.

Test Plan:
- Full dump after warm-up: reset, run 12 cycles, start with first=0, last=31, tx_ready=1. Required: stall_req high after 1 cycle; 32 beats with indices 0..31; tx_last only on index 31; tx_stamp=12; done pulses once.
- Targeted range: preload regs 19/20/21 = 0/10/15, start with first=19, last=21. Required: beats (19,0), (20,10), (21,15,last=1).
- Wrap-around: first=30, last=1. Required: exactly 4 beats with indices 30,31,0,1; tx_last on index 1.
- Backpressure: hold tx_ready=0 for 5 cycles on beat 2. Required: tx_valid, tx_index and tx_data stable throughout; no beat lost or duplicated; stall_req stays high.
- Start while busy, plus reset mid-dump:
  - A second start during SEND is ignored.
  - rst during beat 3 gives IDLE next cycle with stall_req=0, tx_valid=0, no done pulse, and counter=0.
  - A new start after reset behaves normally.
- Drain timing: DRAIN_CYCLES=4. Required: the first READ occurs exactly 4 cycles after stall_req first rises. An instruction in writeback at stall time has its result visible in the dumped value.
